// File: rtl/inst_mem_responder_if.sv
// Fetch-port bundle between requesters and inst_mem_responder.
// rsp_err is present only when INST_MEM_RSP_ERR_EN is defined.
interface inst_mem_responder_if #(
  parameter int mem_port_cnt = 2
);
  logic [mem_port_cnt-1:0]       req_valid;
  logic [mem_port_cnt-1:0][31:0] req_addr;
  logic [mem_port_cnt-1:0][1:0]  req_size;
  logic [mem_port_cnt-1:0][31:0] rsp_data;
  logic [mem_port_cnt-1:0]       rsp_done;
`ifdef INST_MEM_RSP_ERR_EN
  logic [mem_port_cnt-1:0]       rsp_err;

  modport master (
    output req_valid, req_addr, req_size,
    input  rsp_data, rsp_done, rsp_err
  );
  modport slave (
    input  req_valid, req_addr, req_size,
    output rsp_data, rsp_done, rsp_err
  );
`else
  modport master (
    output req_valid, req_addr, req_size,
    input  rsp_data, rsp_done
  );
  modport slave (
    input  req_valid, req_addr, req_size,
    output rsp_data, rsp_done
  );
`endif
endinterface

// File: rtl/inst_mem_responder.sv
// Multi-port instruction memory responder: RR arbiter, fixed-latency read.
// Optional INST_MEM_RSP_ERR_EN adds rsp_err (misaligned / out of range).
module inst_mem_responder #(
  parameter int mem_port_cnt = 2,
  parameter int depth_words  = 1024,
  parameter int read_lat     = 1
) (
  input  logic                clk,
  input  logic                rst,
  inst_mem_responder_if.slave bus,
  input  logic                wr_en,
  input  logic [31:0]         wr_addr,
  input  logic [31:0]         wr_data
);
  localparam int AW = $clog2(depth_words);
  localparam int PW = (mem_port_cnt > 1) ? $clog2(mem_port_cnt) : 1;

  typedef enum logic [1:0] {
    IDLE, QUEUED, INFLIGHT, DONE
  } state_t;

  state_t        st       [mem_port_cnt];
  state_t        st_nx    [mem_port_cnt];
  logic [AW+1:0] cap_addr [mem_port_cnt];
  logic [1:0]    cap_size [mem_port_cnt];
  logic [31:0]   rsp_word [mem_port_cnt];
  logic [PW-1:0] rr;
  logic [31:0]   mem      [depth_words];

  logic          g_vld;
  logic [PW-1:0] g_idx;
  logic [AW+1:0] g_addr;
  logic [1:0]    g_size;
  logic [31:0]   g_word;
  logic [31:0]   g_data;
  logic          x_vld;
  logic [PW-1:0] x_idx;
  logic [31:0]   x_data;
  logic          unused_bits;

`ifdef INST_MEM_RSP_ERR_EN
  logic          cap_oob  [mem_port_cnt];
  logic          rsp_bad  [mem_port_cnt];
  logic          g_err;
  logic          x_err;
`endif

  assign unused_bits = ^{wr_addr, bus.req_addr};

  always_comb begin
    g_vld = 1'b0;
    g_idx = '0;
    for (int k = 0; k < mem_port_cnt; k++) begin
      if (!g_vld &&
          st[(int'(rr) + k) % mem_port_cnt] == QUEUED) begin
        g_vld = 1'b1;
        g_idx = PW'((int'(rr) + k) % mem_port_cnt);
      end
    end
  end

  // store is sampled before this edge's write lands
  always_comb begin
    g_addr = cap_addr[g_idx];
    g_size = cap_size[g_idx];
    g_word = mem[g_addr[AW+1:2]];
    unique case (1'b1)
      g_size == 2'd0:
        g_data = {24'd0, g_word[{g_addr[1:0], 3'b000} +: 8]};
      g_size == 2'd1:
        g_data = {16'd0, g_word[{g_addr[1], 4'b0000} +: 16]};
      default:
        g_data = g_word;
    endcase
`ifdef INST_MEM_RSP_ERR_EN
    g_err = cap_oob[g_idx]
          | ((g_size == 2'd1) & g_addr[0])
          | (g_size[1] & (|g_addr[1:0]));
    if (g_err) g_data = '0;
`endif
  end

  if (read_lat == 1) begin : g_nopipe
    assign x_vld  = g_vld;
    assign x_idx  = g_idx;
    assign x_data = g_data;
`ifdef INST_MEM_RSP_ERR_EN
    assign x_err  = g_err;
`endif
  end else begin : g_pipe
    logic [read_lat-2:0] pv;
    logic [PW-1:0]       pi [read_lat-1];
    logic [31:0]         pd [read_lat-1];
`ifdef INST_MEM_RSP_ERR_EN
    logic                pe [read_lat-1];
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        pv <= '0;
      end else begin
        pv[0] <= g_vld;
        for (int k = 1; k < read_lat - 1; k++)
          pv[k] <= pv[k-1];
      end
      pi[0] <= g_idx;
      pd[0] <= g_data;
      for (int k = 1; k < read_lat - 1; k++) begin
        pi[k] <= pi[k-1];
        pd[k] <= pd[k-1];
      end
`ifdef INST_MEM_RSP_ERR_EN
      pe[0] <= g_err;
      for (int k = 1; k < read_lat - 1; k++)
        pe[k] <= pe[k-1];
`endif
    end

    assign x_vld  = pv[read_lat-2];
    assign x_idx  = pi[read_lat-2];
    assign x_data = pd[read_lat-2];
`ifdef INST_MEM_RSP_ERR_EN
    assign x_err  = pe[read_lat-2];
`endif
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < mem_port_cnt; i++) begin
      if (rst) st[i] <= IDLE;
      else     st[i] <= st_nx[i];
    end
  end

  always_comb begin
    for (int i = 0; i < mem_port_cnt; i++) begin
      st_nx[i] = st[i];
      unique case (st[i])
        IDLE:
          if (bus.req_valid[i]) st_nx[i] = QUEUED;
        QUEUED:
          if (x_vld && x_idx == PW'(i))      st_nx[i] = DONE;
          else if (g_vld && g_idx == PW'(i)) st_nx[i] = INFLIGHT;
        INFLIGHT:
          if (x_vld && x_idx == PW'(i)) st_nx[i] = DONE;
        DONE:
          st_nx[i] = IDLE;
      endcase
    end
  end

  always_comb begin
    for (int i = 0; i < mem_port_cnt; i++) begin
      bus.rsp_done[i] = (st[i] == DONE);
      bus.rsp_data[i] = (st[i] == DONE) ? rsp_word[i] : '0;
`ifdef INST_MEM_RSP_ERR_EN
      bus.rsp_err[i]  = (st[i] == DONE) & rsp_bad[i];
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) rr <= '0;
    else if (g_vld)
      rr <= (g_idx == PW'(mem_port_cnt - 1)) ? '0 : g_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < mem_port_cnt; i++) begin
      if (st[i] == IDLE && bus.req_valid[i]) begin
        cap_addr[i] <= bus.req_addr[i][AW+1:0];
        cap_size[i] <= bus.req_size[i];
`ifdef INST_MEM_RSP_ERR_EN
        cap_oob[i]  <= |(bus.req_addr[i] >> (AW + 2));
`endif
      end
      if (rst) begin
        rsp_word[i] <= '0;
`ifdef INST_MEM_RSP_ERR_EN
        rsp_bad[i]  <= 1'b0;
`endif
      end else if (x_vld && x_idx == PW'(i)) begin
        rsp_word[i] <= x_data;
`ifdef INST_MEM_RSP_ERR_EN
        rsp_bad[i]  <= x_err;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr[AW+1:2]] <= wr_data;
  end
endmodule
